// File: rtl/lcd_hd44780_pkg.sv
// Shared definitions for the HD44780-compatible LCD responder: opcode masks,
// DDRAM geometry, the clear-sequencer state type and address/index mapping.
package lcd_hd44780_pkg;

    localparam logic [7:0] OP_CLEAR      = 8'h01;
    localparam logic [7:0] OP_HOME       = 8'h02;
    localparam logic [7:0] MASK_HOME     = 8'hFE;
    localparam logic [7:0] OP_ENTRY      = 8'h04;
    localparam logic [7:0] MASK_ENTRY    = 8'hFC;
    localparam logic [7:0] OP_DISPCTL    = 8'h08;
    localparam logic [7:0] MASK_DISPCTL  = 8'hF8;
    localparam logic [7:0] OP_SETDDRAM   = 8'h80;
    localparam logic [7:0] MASK_SETDDRAM = 8'h80;

    localparam logic [6:0] ROW0_LAST   = 7'h27;
    localparam logic [6:0] ROW1_FIRST  = 7'h40;
    localparam logic [6:0] ROW1_LAST   = 7'h67;
    localparam logic [6:0] ROW_LEN     = 7'd40;
    localparam int         DDRAM_DEPTH = 80;
    localparam logic [7:0] BLANK_CHAR  = 8'h20;

    typedef enum logic {IDLE, CLEAR} clr_state_e;

    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= ROW0_LAST) || ((a >= ROW1_FIRST) && (a <= ROW1_LAST));
    endfunction

    // Invalid addresses fold onto cell 0 so the RAM is never indexed out of range.
    function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
        if (a <= ROW0_LAST) return a;
        if ((a >= ROW1_FIRST) && (a <= ROW1_LAST)) return a - ROW1_FIRST + ROW_LEN;
        return 7'd0;
    endfunction

    function automatic logic [6:0] idx_to_addr(input logic [6:0] i);
        return (i < ROW_LEN) ? i : i - ROW_LEN + ROW1_FIRST;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == ROW0_LAST) return ROW1_FIRST;
            if (ac == ROW1_LAST) return 7'h00;
            return ac + 7'd1;
        end
        if (ac == 7'h00) return ROW1_LAST;
        if (ac == ROW1_FIRST) return ROW0_LAST;
        return ac - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: one synchronous write port, two registered read ports
// (LCD bus side and host viewer side).
module lcd_ddram
    import lcd_hd44780_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [6:0] widx,
    input  logic [7:0] wdata,
    input  logic [6:0] bus_idx,
    output logic [7:0] bus_rdata,
    input  logic [6:0] view_idx,
    output logic [7:0] view_rdata
);

    logic [7:0] mem_q [DDRAM_DEPTH];
    logic [7:0] bus_rdata_d, bus_rdata_q;
    logic [7:0] view_rdata_d, view_rdata_q;

    // NOTE: the array has no reset; the clear sequencer initialises it after reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[widx] <= wdata;
    end

    always_comb begin
        bus_rdata_d  = mem_q[bus_idx];
        view_rdata_d = mem_q[view_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_rdata_q  <= '0;
            view_rdata_q <= '0;
        end else begin
            bus_rdata_q  <= bus_rdata_d;
            view_rdata_q <= view_rdata_d;
        end
    end

    assign bus_rdata  = bus_rdata_q;
    assign view_rdata = view_rdata_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// LCD-side HD44780-compatible responder: decodes E/RS/RW bus cycles, runs the
// instruction subset, holds DDRAM and answers status/data reads.
module lcd_hd44780_responder
    import lcd_hd44780_pkg::*;
#(
    parameter int BUSY_CYCLES      = 2000,
    parameter int LONG_BUSY_CYCLES = 76500,
    parameter int SYNC_STAGES      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    inout  wire  [7:0] LCD_data,
    input  logic [6:0] disp_addr,
    output logic [7:0] disp_char,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [6:0] cursor_addr,
    output logic       busy,
    output logic       err_write_busy
);

    localparam int SW      = 11;
    localparam int MAX_CYC = (LONG_BUSY_CYCLES > BUSY_CYCLES) ? LONG_BUSY_CYCLES : BUSY_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic [SYNC_STAGES-1:0][SW-1:0] sync_d, sync_q;
    logic       s_e, s_rs, s_rw;
    logic [7:0] s_data;

    always_comb begin
        sync_d[0] = {LCD_E, LCD_RS, LCD_RW, LCD_data};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    // NOTE: synchroniser flops stay unreset so an E held high across reset is not seen as a new rise.
    always_ff @(posedge clk) sync_q <= sync_d;

    assign {s_e, s_rs, s_rw, s_data} = sync_q[SYNC_STAGES-1];

    logic          e_prev_d, e_prev_q, in_cycle_d, in_cycle_q;
    logic          rs_d, rs_q, rw_d, rw_q, bf_d, bf_q;
    logic          rd_pend_d, rd_pend_q, drive_d, drive_q;
    logic [6:0]    ac_d, ac_q;
    logic          id_d, id_q, disp_d, disp_q, cur_d, cur_q, blink_d, blink_q;
    logic          err_d, err_q;
    logic [CW-1:0] cnt_d, cnt_q;
    clr_state_e    state_d, state_q;
    logic [6:0]    clr_idx_d, clr_idx_q;
    logic          clr_we, host_we, start_clear;
    logic          ram_we;
    logic [6:0]    ram_widx;
    logic [7:0]    ram_wdata, bus_rdata, rd_val;
    logic          e_rise, e_fall, wr_fall, wr_ok, rd_fall;

    assign busy    = (cnt_q != '0);
    assign e_rise  = s_e & ~e_prev_q;
    assign e_fall  = ~s_e & e_prev_q & in_cycle_q;
    assign wr_fall = e_fall & ~rw_q;
    assign wr_ok   = wr_fall & ~busy;
    assign rd_fall = e_fall & rw_q & rs_q;

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        e_prev_d    = s_e;
        in_cycle_d  = in_cycle_q;
        rs_d        = rs_q;
        rw_d        = rw_q;
        bf_d        = bf_q;
        rd_pend_d   = e_rise & s_rw;
        drive_d     = (drive_q | rd_pend_q) & ~e_fall;
        ac_d        = ac_q;
        id_d        = id_q;
        disp_d      = disp_q;
        cur_d       = cur_q;
        blink_d     = blink_q;
        err_d       = wr_fall & busy;
        cnt_d       = busy ? cnt_q - CW'(1) : cnt_q;
        host_we     = 1'b0;
        start_clear = 1'b0;

        if (e_rise) begin
            in_cycle_d = 1'b1;
            rs_d       = s_rs;
            rw_d       = s_rw;
            bf_d       = busy;
        end
        if (e_fall) in_cycle_d = 1'b0;

        if (wr_ok) begin
            cnt_d = CW'(BUSY_CYCLES);
            if (rs_q) begin
                host_we = 1'b1;
                ac_d    = ac_step(ac_q, id_q);
            end else if (s_data == OP_CLEAR) begin
                ac_d        = 7'h00;
                id_d        = 1'b1;
                start_clear = 1'b1;
                cnt_d       = CW'(LONG_BUSY_CYCLES);
            end else if ((s_data & MASK_HOME) == OP_HOME) begin
                ac_d  = 7'h00;
                cnt_d = CW'(LONG_BUSY_CYCLES);
            end else if ((s_data & MASK_ENTRY) == OP_ENTRY) begin
                id_d = s_data[1];
            end else if ((s_data & MASK_DISPCTL) == OP_DISPCTL) begin
                {disp_d, cur_d, blink_d} = s_data[2:0];
            end else if ((s_data & MASK_SETDDRAM) == OP_SETDDRAM) begin
                ac_d = addr_valid(s_data[6:0]) ? s_data[6:0] : 7'h00;
            end
        end

        if (rd_fall) ac_d = ac_step(ac_q, id_q);
    end

    // NOTE: sequential state uses non-blocking assignments only; always_comb uses blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_prev_q   <= 1'b1;
            in_cycle_q <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            bf_q       <= 1'b0;
            rd_pend_q  <= 1'b0;
            drive_q    <= 1'b0;
            ac_q       <= 7'h00;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            cur_q      <= 1'b0;
            blink_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= CW'(LONG_BUSY_CYCLES);
        end else begin
            e_prev_q   <= e_prev_d;
            in_cycle_q <= in_cycle_d;
            rs_q       <= rs_d;
            rw_q       <= rw_d;
            bf_q       <= bf_d;
            rd_pend_q  <= rd_pend_d;
            drive_q    <= drive_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            disp_q     <= disp_d;
            cur_q      <= cur_d;
            blink_q    <= blink_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Clear sequencer: reset lands directly in CLEAR so DDRAM is always initialised.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= 7'd0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            IDLE: if (start_clear) begin
                state_d   = CLEAR;
                clr_idx_d = 7'd0;
            end
            CLEAR: if (clr_idx_q == 7'(DDRAM_DEPTH - 1)) begin
                state_d   = IDLE;
                clr_idx_d = 7'd0;
            end else begin
                clr_idx_d = clr_idx_q + 7'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clr_we = (state_q == CLEAR);
    end

    always_comb begin
        ram_we    = clr_we | host_we;
        ram_widx  = clr_we ? clr_idx_q : addr_to_idx(ac_q);
        ram_wdata = clr_we ? BLANK_CHAR : s_data;
        rd_val    = rs_q ? bus_rdata : {bf_q, ac_q};
    end

    lcd_ddram u_ddram (
        .clk        (clk),
        .reset      (reset),
        .we         (ram_we),
        .widx       (ram_widx),
        .wdata      (ram_wdata),
        .bus_idx    (addr_to_idx(ac_q)),
        .bus_rdata  (bus_rdata),
        .view_idx   (addr_to_idx(disp_addr)),
        .view_rdata (disp_char)
    );

    assign LCD_data       = drive_q ? rd_val : 8'bz;
    assign display_on     = disp_q;
    assign cursor_on      = cur_q;
    assign blink_on       = blink_q;
    assign cursor_addr    = ac_q;
    assign err_write_busy = err_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: drives HD44780 bus cycles and
// checks registers, DDRAM (through the viewer port), busy timing and the bus.
module tb_lcd_hd44780_responder;

    localparam int BUSY = 20;
    localparam int LONG = 120;

    logic       clk = 1'b0;
    logic       reset, lcd_e, lcd_rs, lcd_rw, tb_oe;
    logic [7:0] tb_drv;
    wire  [7:0] lcd_data;
    logic [6:0] disp_addr;
    logic [7:0] disp_char;
    logic       display_on, cursor_on, blink_on, busy, err_write_busy;
    logic [6:0] cursor_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign lcd_data = tb_oe ? tb_drv : 8'bz;

    lcd_hd44780_responder #(
        .BUSY_CYCLES      (BUSY),
        .LONG_BUSY_CYCLES (LONG),
        .SYNC_STAGES      (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .LCD_E          (lcd_e),
        .LCD_RS         (lcd_rs),
        .LCD_RW         (lcd_rw),
        .LCD_data       (lcd_data),
        .disp_addr      (disp_addr),
        .disp_char      (disp_char),
        .display_on     (display_on),
        .cursor_on      (cursor_on),
        .blink_on       (blink_on),
        .cursor_addr    (cursor_addr),
        .busy           (busy),
        .err_write_busy (err_write_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ends one sample (#1) after the clock edge on which the write takes effect.
    task automatic lcd_write(input logic rs, input logic [7:0] d);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = 1'b0; tb_drv = d; tb_oe = 1'b1;
        repeat (2) @(posedge clk); #1;
        lcd_e = 1'b1;
        repeat (6) @(posedge clk); #1;
        lcd_e = 1'b0;
        repeat (3) @(posedge clk); #1;
        tb_oe = 1'b0;
    endtask

    task automatic lcd_read(input logic rs, input logic flip_rw, output logic [7:0] d);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = 1'b1; tb_oe = 1'b0;
        repeat (2) @(posedge clk); #1;
        lcd_e = 1'b1;
        repeat (2) @(posedge clk); #1;
        if (flip_rw) lcd_rw = 1'b0;
        repeat (4) @(posedge clk); #1;
        d = lcd_data;
        lcd_e = 1'b0;
        repeat (3) @(posedge clk); #1;
    endtask

    // Counts samples with busy high, starting at the current sample; bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic view(input logic [6:0] a, output logic [7:0] v);
        disp_addr = a;
        @(posedge clk); #1;
        v = disp_char;
    endtask

    // The bench drives a marker; it reads back intact only if the DUT is off the bus.
    task automatic check_released(input string tag);
        tb_drv = 8'hA5; tb_oe = 1'b1;
        #1;
        check(tag, lcd_data, 8'hA5);
        tb_oe = 1'b0;
    endtask

    task automatic check_all_blank(input string tag);
        logic [7:0] v;
        for (int a = 0; a < 128; a++) begin
            if ((a <= 'h27) || (a >= 'h40 && a <= 'h67)) begin
                view(7'(a), v);
                check($sformatf("%s_%02h", tag, a), v, 8'h20);
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        int n, t0;

        reset = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        tb_oe = 1'b0; tb_drv = 8'h00; disp_addr = 7'h00;
        repeat (3) @(posedge clk); #1;

        check("rst_ac", cursor_addr, 7'h00);
        check("rst_dcb", {display_on, cursor_on, blink_on}, 3'b000);
        check("rst_err", err_write_busy, 1'b0);
        check("rst_disp_char", disp_char, 8'h00);
        check("rst_busy", busy, 1'b1);
        check_released("rst_bus");
        reset = 1'b0;
        t0 = cyc;

        lcd_read(1'b0, 1'b0, d);
        check("status_busy", d, 8'h80);
        wait_idle(n);
        check("long_busy_cycles", cyc - t0, LONG);
        lcd_read(1'b0, 1'b0, d);
        check("status_idle", d, 8'h00);
        check_all_blank("init_cell");

        lcd_write(1'b0, 8'h0F);
        wait_idle(n);
        check("short_busy_cycles", n, BUSY);
        check("dcb_on", {display_on, cursor_on, blink_on}, 3'b111);
        lcd_write(1'b1, 8'h41);
        wait_idle(n);
        check("ac_after_data", cursor_addr, 7'h01);
        view(7'h00, d);
        check("ddram_00", d, 8'h41);

        lcd_write(1'b0, 8'hA7);
        wait_idle(n);
        check("ac_set_27", cursor_addr, 7'h27);
        lcd_write(1'b1, 8'h42);
        wait_idle(n);
        check("ac_wrap_inc_27", cursor_addr, 7'h40);
        view(7'h27, d);
        check("ddram_27", d, 8'h42);

        lcd_write(1'b0, 8'hB0);
        wait_idle(n);
        check("ac_invalid_set", cursor_addr, 7'h00);

        lcd_write(1'b0, 8'h04);
        wait_idle(n);
        lcd_write(1'b0, 8'h80);
        wait_idle(n);
        lcd_write(1'b1, 8'h41);
        wait_idle(n);
        check("ac_wrap_dec_00", cursor_addr, 7'h67);
        view(7'h67, d);
        check("ddram_67_blank", d, 8'h20);
        lcd_write(1'b0, 8'hC0);
        wait_idle(n);
        lcd_write(1'b1, 8'h45);
        wait_idle(n);
        check("ac_wrap_dec_40", cursor_addr, 7'h27);
        view(7'h40, d);
        check("ddram_40", d, 8'h45);

        lcd_write(1'b0, 8'h06);
        wait_idle(n);
        lcd_write(1'b0, 8'h90);
        wait_idle(n);
        lcd_write(1'b1, 8'h55);
        check("err_quiet", err_write_busy, 1'b0);
        lcd_write(1'b1, 8'h66);
        check("err_pulse", err_write_busy, 1'b1);
        @(posedge clk); #1;
        check("err_one_cycle", err_write_busy, 1'b0);
        wait_idle(n);
        check("busy_not_reloaded", n, 7);
        check("ac_after_drop", cursor_addr, 7'h11);
        view(7'h10, d);
        check("ddram_10", d, 8'h55);
        view(7'h11, d);
        check("ddram_11_untouched", d, 8'h20);

        lcd_write(1'b0, 8'h80);
        wait_idle(n);
        lcd_read(1'b1, 1'b1, d);
        check("data_read", d, 8'h41);
        check_released("data_read_release");
        check("ac_after_read", cursor_addr, 7'h01);
        check("read_no_write", busy, 1'b0);
        view(7'h00, d);
        check("ddram_00_after_read", d, 8'h41);
        lcd_read(1'b0, 1'b0, d);
        check("status_ac01", d, 8'h01);

        lcd_write(1'b0, 8'h01);
        repeat (10) @(posedge clk); #1;
        lcd_rs = 1'b0; lcd_rw = 1'b1;
        repeat (2) @(posedge clk); #1;
        lcd_e = 1'b1;
        repeat (6) @(posedge clk); #1;
        check("midclear_status", lcd_data, 8'h80);
        reset = 1'b1;
        @(posedge clk); #1;
        check_released("reset_bus_release");
        check("reset_dcb", {display_on, cursor_on, blink_on}, 3'b000);
        @(posedge clk); #1;
        reset = 1'b0;
        t0 = cyc;
        repeat (6) @(posedge clk); #1;
        check_released("reset_e_high_no_read");
        lcd_e = 1'b0;
        repeat (5) @(posedge clk); #1;
        check_released("reset_e_fall_no_read");
        check("reset_ac", cursor_addr, 7'h00);
        wait_idle(n);
        check("reset_long_busy", cyc - t0, LONG);
        check_all_blank("reclear_cell");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
